// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Fetch-entry bundle and fetch defaults.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue storage: circular buffer of fetch entries.
// Clear empties it; keep_head trims it to the head entry alone.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic         keep_head,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (keep_head) begin
      wr_ptr <= rd_ptr + AW'(1);
      count  <= (AW+1)'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the PC and prefetches into a queue.
// Decode consumes over valid/ready; redirects may keep the delay slot.
module fetch_queue_stage
  import mips_pkg::*;
#(
  parameter  int          DEPTH      = 4,
  parameter  logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter  bit          DELAY_SLOT = 1'b1,
  localparam int          CW         = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [31:0]        d_pc,
  output logic [31:0]        d_pc4,
  output logic [INSTR_W-1:0] d_instr,
  output logic [CW-1:0]      count
);

  logic [31:0]  pc;
  logic         empty;
  logic         full;
  logic         pop;
  logic         fetch;
  logic         push;
  logic         clear;
  logic         keep_head;
  logic         unused_lo;
  fetch_entry_t entry;
  fetch_entry_t head;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign d_valid = !empty;
  assign pop     = d_valid & d_ready;
  assign fetch   = !reset & (!full | pop);

  // On redirect only an empty queue with delay slots takes a write
  assign push      = fetch & (!redirect | (DELAY_SLOT & empty));
  assign clear     = redirect & (!DELAY_SLOT | pop);
  assign keep_head = redirect & DELAY_SLOT & !empty & !pop;

  assign imem_en   = push;
  assign imem_addr = pc;
  assign entry     = '{pc: pc, instr: imem_rdata};
  assign unused_lo = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= {redirect_pc[31:2], 2'b00};
    else if (push)     pc <= pc + 32'd4;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .keep_head (keep_head),
    .wdata     (entry),
    .rdata     (head),
    .count     (count)
  );

  assign d_pc    = d_valid ? head.pc : '0;
  assign d_pc4   = d_valid ? head.pc + 32'd4 : '0;
  assign d_instr = d_valid ? head.instr : '0;

endmodule
